pipelined_controller: RTL

- Successor to the single-cycle instruction decoder. Decodes a 32-bit RV32I instruction in ID and carries its control bits through internal ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and stalls ID. Squashes on a taken branch.
- Sits beside the datapath pipeline registers. The datapath consumes the per-stage control outputs.

---
 rtl/pipelined_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_controller.sv
// Pipelined RV32I control path: decodes in ID and carries control bits through ID/EX, EX/MEM, MEM/WB.
// Optional perf counters (stall/flush/bubble) are compiled in when PIPE_PERF_COUNTERS_EN is defined.
module pipelined_controller #(
  parameter int ALU_CTRL_W    = 3,
  parameter int REG_ADDR_W    = 5,
  parameter bit OPCODE_STRICT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           instruction,
  input  logic                  branch_taken,
  output logic                  id_ready,
  output logic                  flush,
  output logic                  illegal,
  output logic                  ex_valid,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count,
  output logic [31:0]           bubble_count
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_op;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  ctrl_t                 dec, idex, idex_d;
  logic                  uses_rs2, undefined_op, hazard, squash, stall;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  mem_reg_write, mem_to_reg_q;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  unused_bits;

  assign funct3      = instruction[14:12];
  assign rs1         = REG_ADDR_W'(instruction[19:15]);
  assign rs2         = REG_ADDR_W'(instruction[24:20]);
  assign unused_bits = ^{instruction[31], instruction[29:25]};

  // alt selects SUB only for funct3=000; funct3=101 is always SRL (no SRA in this ALU)
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:         alu_from_funct3 = alt ? 3'd1 : 3'd0;
      3'b001:         alu_from_funct3 = 3'd6;
      3'b010, 3'b011: alu_from_funct3 = 3'd5;
      3'b100:         alu_from_funct3 = 3'd4;
      3'b101:         alu_from_funct3 = 3'd7;
      3'b110:         alu_from_funct3 = 3'd3;
      default:        alu_from_funct3 = 3'd2;
    endcase
  endfunction

  always_comb begin
    dec          = '0;
    uses_rs2     = 1'b0;
    undefined_op = 1'b0;
    case (instruction[6:0])
      OP_R: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_CTRL_W'(alu_from_funct3(funct3, instruction[30]));
        dec.rd        = REG_ADDR_W'(instruction[11:7]);
        uses_rs2      = 1'b1;
      end
      OP_I: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_CTRL_W'(alu_from_funct3(funct3, 1'b0));
        dec.rd        = REG_ADDR_W'(instruction[11:7]);
      end
      OP_LOAD: begin
        dec.valid      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.rd         = REG_ADDR_W'(instruction[11:7]);
      end
      OP_STORE: begin
        dec.valid     = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.valid  = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = ALU_CTRL_W'(3'd1);
        uses_rs2   = 1'b1;
      end
      default: undefined_op = 1'b1;
    endcase
    if (dec.rd == '0) dec.reg_write = 1'b0;
    if (!id_valid) dec = '0;
  end

  // Load-use: EX load feeding a source of the valid ID instruction; a taken branch overrides it
  assign hazard = id_valid & idex.valid & idex.mem_read & (idex.rd != '0) &
                  ((rs1 == idex.rd) | (uses_rs2 & (rs2 == idex.rd)));
  assign squash   = idex.valid & idex.branch & branch_taken;
  assign stall    = hazard & ~squash;
  assign id_ready = ~stall;
  assign flush    = squash;
  assign illegal  = OPCODE_STRICT & id_valid & undefined_op & ~stall & ~squash;
  assign idex_d   = (stall | squash) ? '0 : dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex          <= '0;
      mem_valid     <= 1'b0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
    end else begin
      idex          <= idex_d;
      mem_valid     <= idex.valid;
      mem_write     <= idex.mem_write;
      mem_read      <= idex.mem_read;
      mem_reg_write <= idex.reg_write;
      mem_to_reg_q  <= idex.mem_to_reg;
      mem_rd        <= idex.rd;
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_mem_to_reg <= mem_to_reg_q;
      wb_rd         <= mem_rd;
    end
  end

  assign ex_valid       = idex.valid;
  assign ex_alu_control = idex.alu_op;
  assign ex_alu_src     = idex.alu_src;
  assign ex_branch      = idex.branch;
  assign ex_rd          = idex.rd;

`ifdef PIPE_PERF_COUNTERS_EN
  // Saturating event counters; a bubble is any cycle where EX is loaded with an empty slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count  <= '0;
      flush_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
      if (squash && flush_count != '1) flush_count <= flush_count + 32'd1;
      if (!idex_d.valid && bubble_count != '1) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
